// File: rtl/serial_deserializer_pkg.sv
// Shared types and default sizing for the serial deserializer front end.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } deser_state_t;

   localparam int DATA_WIDTH_DEF     = 8;
   localparam int SYNC_STAGES_DEF    = 2;
   localparam int TIMEOUT_CYCLES_DEF = 1000;

endpackage

// File: rtl/serial_deserializer_sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous strobe plus a single-cycle
// rising-edge pulse derived from the synchronised level.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_d;

   // Walk the pin through the synchroniser chain and keep one delayed copy of the settled level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         sync_d <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         sync_d <= sync_q[SYNC_STAGES-1];
      end
   end

   // A held-high level produces exactly one pulse; a new pulse needs a low in between.
   assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel front end: captures one data bit per write strobe edge,
// LSB first, and hands each complete word to the byte queue over valid/ready.
module serial_deserializer
   import serial_pkg::*;
#(
   parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                  clock_1MHz,
   input  logic                  rst,
   input  logic                  data_in,
   input  logic                  write_in,
   input  logic                  data_ready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  status_out,
   output logic                  overrun_out,
   output logic                  timeout_out
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DATA_WIDTH);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   deser_state_t           state;
   logic [DATA_WIDTH-1:0]  shift_q;
   logic [CNT_W-1:0]       bit_cnt;
   logic [TO_W-1:0]        to_cnt;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   data_bit;
   logic                   write_rise;

   sync_edge_detect #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_write_sync (
      .clk      (clock_1MHz),
      .rst      (rst),
      .async_in (write_in),
      .rise     (write_rise)
   );

   // Data pin gets a chain of equal length so the sampled bit lines up with the strobe edge.
   always_ff @(posedge clock_1MHz) begin
      if (rst) begin
         data_sync <= '0;
      end else begin
         data_sync <= {data_sync[SYNC_STAGES-2:0], data_in};
      end
   end

   assign data_bit = data_sync[SYNC_STAGES-1];

   // Main controller: bit assembly, word hand-off, partial-word timeout and overrun reporting.
   always_ff @(posedge clock_1MHz) begin
      if (rst) begin
         state       <= IDLE;
         shift_q     <= '0;
         bit_cnt     <= '0;
         to_cnt      <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         status_out  <= 1'b1;
         overrun_out <= 1'b0;
         timeout_out <= 1'b0;
      end else begin
         overrun_out <= 1'b0;
         timeout_out <= 1'b0;
         case (state)
            IDLE: begin
               status_out <= 1'b1;
               bit_cnt    <= '0;
               to_cnt     <= '0;
               if (write_rise) begin
                  shift_q[0] <= data_bit;
                  bit_cnt    <= CNT_W'(1);
                  status_out <= 1'b0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               if (bit_cnt == FULL_CNT) begin
                  data_out   <= shift_q;
                  data_valid <= 1'b1;
                  to_cnt     <= '0;
                  state      <= HOLD;
                  if (write_rise) begin
                     overrun_out <= 1'b1;
                  end
               end else if (write_rise) begin
                  for (int i = 0; i < DATA_WIDTH; i++) begin
                     if (bit_cnt == CNT_W'(i)) begin
                        shift_q[i] <= data_bit;
                     end
                  end
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  to_cnt  <= '0;
               end else if (to_cnt == TO_LAST) begin
                  timeout_out <= 1'b1;
                  bit_cnt     <= '0;
                  to_cnt      <= '0;
                  status_out  <= 1'b1;
                  state       <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end
            HOLD: begin
               if (write_rise) begin
                  overrun_out <= 1'b1;
               end
               if (data_ready) begin
                  data_valid <= 1'b0;
                  bit_cnt    <= '0;
                  status_out <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: begin
               data_valid <= 1'b0;
               bit_cnt    <= '0;
               to_cnt     <= '0;
               status_out <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed plus randomized bench for serial_deserializer with a short timeout.
`timescale 1ns/1ps
module tb_serial_deserializer;

   localparam int DW      = 8;
   localparam int SS      = 2;
   localparam int TO      = 100;
   localparam int LATENCY = SS + 2;

   logic          clock_1MHz = 1'b0;
   logic          rst;
   logic          data_in;
   logic          write_in;
   logic          data_ready;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          status_out;
   logic          overrun_out;
   logic          timeout_out;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   logic [DW-1:0] got_words[$];
   int            got_cycles[$];
   int            overrun_cnt    = 0;
   int            timeout_cnt    = 0;
   int            timeout_cyc    = -1;
   int            valid_run      = 0;
   int            last_valid_run = 0;
   logic          valid_prev     = 1'b0;
   int            last_edge_cyc  = 0;

   serial_deserializer #(
      .DATA_WIDTH     (DW),
      .SYNC_STAGES    (SS),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock_1MHz  (clock_1MHz),
      .rst         (rst),
      .data_in     (data_in),
      .write_in    (write_in),
      .data_ready  (data_ready),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .status_out  (status_out),
      .overrun_out (overrun_out),
      .timeout_out (timeout_out)
   );

   // 1 MHz system clock
   always #500 clock_1MHz = ~clock_1MHz;

   // cycle index, bumped on every active edge
   always @(posedge clock_1MHz) cyc++;

   // observe outputs mid-cycle: log each new word, valid run length and pulses
   always @(negedge clock_1MHz) begin
      if (rst) begin
         valid_run = 0;
      end else begin
         if (data_valid && !valid_prev) begin
            got_words.push_back(data_out);
            got_cycles.push_back(cyc);
         end
         if (data_valid) begin
            valid_run++;
         end else begin
            if (valid_run > 0) last_valid_run = valid_run;
            valid_run = 0;
         end
         if (overrun_out) overrun_cnt++;
         if (timeout_out) begin
            timeout_cnt++;
            timeout_cyc = cyc;
         end
      end
      valid_prev = data_valid;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock_1MHz);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // one strobe pulse carrying bit b; remembers the cycle of the pin rising edge
   task automatic apply_stimulus(input logic b, input int hi, input int lo);
      data_in       = b;
      write_in      = 1'b1;
      last_edge_cyc = cyc;
      tick(hi);
      write_in = 1'b0;
      tick(lo);
   endtask

   task automatic send_word(input logic [DW-1:0] w, input int hi, input int lo);
      for (int i = 0; i < DW; i++) apply_stimulus(w[i], hi, lo);
   endtask

   // wait (bounded) for the next word and compare value and edge-to-valid latency
   task automatic expect_word(input string tag, input logic [DW-1:0] exp);
      int waited = 0;
      while (got_words.size() == 0 && waited < 300) begin
         tick(1);
         waited++;
      end
      if (got_words.size() == 0) begin
         check_output({tag, "_arrive"}, got_words.size(), 1);
      end else begin
         logic [DW-1:0] w;
         int            c;
         w = got_words.pop_front();
         c = got_cycles.pop_front();
         check_output({tag, "_word"}, w, exp);
         check_output({tag, "_latency"}, c - last_edge_cyc, LATENCY);
      end
   endtask

   initial begin
      logic [DW-1:0] w;
      logic [DW-1:0] held_exp;
      int            t0;
      int            ov0;
      int            waited;
      int            hold_cycles;

      // reset held for three cycles
      rst        = 1'b1;
      data_in    = 1'b0;
      write_in   = 1'b0;
      data_ready = 1'b1;
      tick(3);
      check_output("rst_status", status_out, 1);
      check_output("rst_valid", data_valid, 0);
      check_output("rst_data", data_out, 0);
      check_output("rst_overrun", overrun_out, 0);
      check_output("rst_timeout", timeout_out, 0);
      rst = 1'b0;
      tick(2);

      // 0x99 with a ready queue: one-cycle valid, status drops after first capture
      $display("[TB] byte 0x99 with data_ready=1");
      w = 8'h99;
      check_output("b99_status_idle", status_out, 1);
      apply_stimulus(w[0], 10, 10);
      check_output("b99_status_busy", status_out, 0);
      for (int i = 1; i < DW; i++) apply_stimulus(w[i], 10, 10);
      expect_word("b99", 8'h99);
      check_output("b99_valid_len", last_valid_run, 1);
      check_output("b99_status_back", status_out, 1);
      check_output("b99_data_kept", data_out, 8'h99);

      // backpressure: word held stable, extra strobe reported as overrun and dropped
      $display("[TB] backpressure and overrun");
      data_ready = 1'b0;
      send_word(8'h99, 10, 10);
      expect_word("bp", 8'h99);
      for (int i = 0; i < 5; i++) begin
         tick(10);
         check_output("bp_valid_held", data_valid, 1);
         check_output("bp_data_stable", data_out, 8'h99);
      end
      check_output("bp_status", status_out, 0);
      ov0 = overrun_cnt;
      apply_stimulus(1'b0, 10, 10);
      tick(5);
      check_output("bp_overrun_pulse", overrun_cnt, ov0 + 1);
      check_output("bp_word_unchanged", data_out, 8'h99);
      data_ready = 1'b1;
      tick(1);
      check_output("bp_release_valid", data_valid, 0);
      check_output("bp_release_status", status_out, 1);
      tick(10);
      check_output("bp_no_extra_word", got_words.size(), 0);

      // timeout: three bits then silence
      $display("[TB] partial word timeout");
      t0 = timeout_cnt;
      for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 5, 5);
      waited = 0;
      while (timeout_cnt == t0 && waited < 200) begin
         tick(1);
         waited++;
      end
      check_output("to_pulse", timeout_cnt, t0 + 1);
      check_output("to_cycle", timeout_cyc, last_edge_cyc + SS + 1 + TO);
      tick(1);
      check_output("to_status", status_out, 1);
      send_word(8'h5A, 6, 6);
      expect_word("after_to", 8'h5A);

      // reset in the middle of a word
      $display("[TB] reset mid-word");
      for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 5, 5);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_output("midrst_status", status_out, 1);
      check_output("midrst_valid", data_valid, 0);
      tick(2);
      send_word(8'hA5, 5, 5);
      expect_word("after_rst", 8'hA5);

      // held strobe counts once; kept shorter than the timeout of this instance
      $display("[TB] held strobe");
      tick(5);
      apply_stimulus(1'b1, 80, 5);
      check_output("held_status", status_out, 0);
      check_output("held_no_valid", data_valid, 0);
      held_exp    = '0;
      held_exp[0] = 1'b1;
      w = DW'($urandom);
      for (int i = 1; i < DW - 1; i++) begin
         apply_stimulus(w[i], 4, 4);
         held_exp[i] = w[i];
      end
      check_output("held_6_more_no_word", got_words.size(), 0);
      apply_stimulus(w[DW-1], 4, 4);
      held_exp[DW-1] = w[DW-1];
      expect_word("held", held_exp);

      // random words, random strobe widths, occasional backpressure
      $display("[TB] random traffic");
      for (int n = 0; n < 12; n++) begin
         tick(3);
         w          = DW'($urandom);
         data_ready = ($urandom_range(0, 2) != 0);
         send_word(w, $urandom_range(2, 8), $urandom_range(2, 8));
         expect_word("rnd", w);
         if (!data_ready) begin
            hold_cycles = $urandom_range(1, 20);
            tick(hold_cycles);
            check_output("rnd_hold_data", data_out, w);
            data_ready = 1'b1;
            tick(1);
            check_output("rnd_release", data_valid, 0);
         end
      end

      tick(10);
      check_output("total_overruns", overrun_cnt, 1);
      check_output("total_timeouts", timeout_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
